dma_ahb_slave: RTL

AHB-Lite responder for the DMA register window. The bus arbiter/decoder routes CPU accesses at 0x40000010, 0x40000060 and 0x40000090 to this block. It holds the DMA source, destination and control/status registers, and handles address/data-phase pipelining, wait states and two-cycle ERROR responses. It hands programmed values and a one-cycle start pulse to the DMA engine, and collects busy/done back from it.

---
 rtl/dma_ahb_slave_if.sv | 40 ++++
 rtl/dma_ahb_slave.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_ahb_slave_if.sv
// AHB-Lite bus bundle between the CPU-side decoder and the DMA register window.
// The responder drives hready_o/hresp_o/hrdata_o; everything else comes from the master side.
interface dma_ahb_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hready_o;
    logic        hresp_o;
    logic [31:0] hrdata_o;

    modport master (
        output hsel,
        output haddr,
        output htrans,
        output hwrite,
        output hsize,
        output hwdata,
        output hready,
        input  hready_o,
        input  hresp_o,
        input  hrdata_o
    );

    modport slave (
        input  hsel,
        input  haddr,
        input  htrans,
        input  hwrite,
        input  hsize,
        input  hwdata,
        input  hready,
        output hready_o,
        output hresp_o,
        output hrdata_o
    );
endinterface

// File: rtl/dma_ahb_slave.sv
// AHB-Lite responder holding the DMA SRC/DST/CTRL registers.
// Define DMA_IRQ_EN to enable the IE bit and the registered dma_irq output.
module dma_ahb_slave #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000
) (
    input  logic            hclk,
    input  logic            hreset,
    dma_ahb_slave_if.slave  bus,
    output logic [31:0]     dma_src,
    output logic [31:0]     dma_dst,
    output logic [15:0]     dma_len,
    output logic            dma_start,
    input  logic            dma_busy,
    input  logic            dma_done,
    output logic            dma_irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    typedef enum logic [1:0] {
        R_SRC,
        R_DST,
        R_CTRL,
        R_NONE
    } reg_t;

    localparam logic [31:0] LP_MASK = 32'hFFFF_FF00;
    localparam logic [2:0]  LP_WCNT =
        (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t      r_state;
    reg_t        r_reg;
    logic        r_write;
    logic        r_dp;
    logic        r_hready;
    logic        r_hresp;
    logic [2:0]  r_cnt;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [15:0] r_len;
    logic        r_start;
    logic        r_done;

    logic        w_accept;
    logic        w_base;
    logic        w_legal;
    reg_t        w_reg;
    logic        w_wr_done;
    logic        w_wr_ctrl;
    logic        w_go;
    logic        w_w1c;
    logic        w_zero_len;
    logic        w_ie;
    logic [31:0] w_ctrl;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_accept = bus.hsel & bus.htrans[1] & bus.hready & r_hready;
    assign w_base   = (bus.haddr & LP_MASK) == (BASE_ADDR & LP_MASK);

    always_comb begin
        w_reg = R_NONE;
        if (w_base) begin
            unique case (bus.haddr[7:0])
                8'h10:   w_reg = R_SRC;
                8'h60:   w_reg = R_DST;
                8'h90:   w_reg = R_CTRL;
                default: w_reg = R_NONE;
            endcase
        end
    end

    // Legality is judged once, as the transfer moves into its data phase.
    assign w_legal = (w_reg != R_NONE)
                   & (bus.hsize == 3'b010)
                   & ~(bus.hwrite & dma_busy);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
            r_dp     <= 1'b0;
            r_write  <= 1'b0;
            r_reg    <= R_NONE;
            r_cnt    <= 3'd0;
        end else begin
            unique case (r_state)
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state  <= S_IDLE;
                        r_hready <= 1'b1;
                        r_dp     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_ERR1: begin
                    r_state  <= S_ERR2;
                    r_hready <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b0;
                    r_dp     <= 1'b0;
                    if (w_accept) begin
                        r_write <= bus.hwrite;
                        r_reg   <= w_reg;
                        if (!w_legal) begin
                            r_state  <= S_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            r_state  <= S_WAIT;
                            r_hready <= 1'b0;
                            r_cnt    <= LP_WCNT;
                        end else begin
                            r_dp <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign w_wr_done  = r_dp & r_write;
    assign w_wr_ctrl  = w_wr_done & (r_reg == R_CTRL);
    assign w_go       = w_wr_ctrl & bus.hwdata[31];
    assign w_w1c      = w_wr_ctrl & bus.hwdata[30];
    assign w_zero_len = bus.hwdata[15:0] == 16'd0;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_src   <= 32'd0;
            r_dst   <= 32'd0;
            r_len   <= 16'd0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_wr_done) begin
                unique case (r_reg)
                    R_SRC:   r_src <= bus.hwdata;
                    R_DST:   r_dst <= bus.hwdata;
                    R_CTRL:  r_len <= bus.hwdata[15:0];
                    default: ;
                endcase
            end
            r_start <= w_go & ~w_zero_len;
            // An engine completion outranks a same-cycle W1C.
            r_done  <= dma_done
                     | (w_go & w_zero_len)
                     | (r_done & ~w_w1c);
        end
    end

`ifdef DMA_IRQ_EN
    logic r_ie;
    logic r_irq;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ie <= bus.hwdata[28];
            end
            r_irq <= r_done & r_ie;
        end
    end

    assign w_ie    = r_ie;
    assign dma_irq = r_irq;
`else
    logic w_unused_ie;

    assign w_unused_ie = bus.hwdata[28];
    assign w_ie        = 1'b0;
    assign dma_irq     = 1'b0;
`endif

    assign w_ctrl = {1'b0, r_done, dma_busy, w_ie, 12'd0, r_len};

    always_comb begin
        w_rdata = 32'd0;
        if (r_dp && !r_write) begin
            unique case (1'b1)
                r_reg == R_SRC:  w_rdata = r_src;
                r_reg == R_DST:  w_rdata = r_dst;
                r_reg == R_CTRL: w_rdata = w_ctrl;
                default:         w_rdata = 32'd0;
            endcase
        end
    end

    assign w_unused = ^{bus.htrans[0], bus.hwdata[29], bus.hwdata[27:16]};

    assign bus.hready_o = r_hready;
    assign bus.hresp_o  = r_hresp;
    assign bus.hrdata_o = w_rdata;
    assign dma_src      = r_src;
    assign dma_dst      = r_dst;
    assign dma_len      = r_len;
    assign dma_start    = r_start;

endmodule
